wb_timeout_bridge: RTL and testbench
====================================

Name: wb_timeout_bridge

Overview:
- Registered Wishbone bridge between the CPU external-bus master and the crossbar (`wb_xbar`).
- Adds one register stage on the request and response paths for timing closure.
- Watches every forwarded transaction. If the downstream slave never acks (unmapped address, hung peripheral), it terminates the access with an error, so the CPU cannot stall forever.

Parameters:
- TIMEOUT_CYCLES, 255: max cycles a forwarded access waits for s_ack_i; legal range 1..65535.
- ERR_DATA, 32'hDEADBEEF: read data returned on a timed-out access.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- m_adr_i  in  32  master address
- m_dat_i  in  32  master write data
- m_dat_o  out  32  read data to master
- m_we_i  in  1  write enable
- m_sel_i  in  4  byte selects
- m_stb_i  in  1  strobe
- m_cyc_i  in  1  cycle
- m_ack_o  out  1  ack to master
- m_err_o  out  1  error to master (timeout)
- s_adr_o  out  32  address to xbar
- s_dat_o  out  32  write data to xbar
- s_dat_i  in  32  read data from xbar
- s_we_o  out  1  write enable to xbar
- s_sel_o  out  4  byte selects to xbar
- s_stb_o  out  1  strobe to xbar
- s_cyc_o  out  1  cycle to xbar
- s_ack_i  in  1  ack from xbar
- to_count_o  out  16  saturating timeout counter (optional feature)
- to_last_adr_o  out  32  address of most recent timed-out access (optional feature)

Behaviour:
- Reset (rst=1 at a rising edge): every output is 0; state=IDLE; timer=0.
- States: IDLE, BUSY, RESP.
- IDLE:
  - On m_cyc_i & m_stb_i: latch adr/dat/we/sel into the request register, clear the timer, go to BUSY.
  - s_* outputs take the latched values on the same edge, so s_cyc_o=s_stb_o=1 from cycle N+1 when the request is seen in cycle N.
- BUSY:
  - s_cyc_o=s_stb_o=1 and s_adr/dat/we/sel are held stable.
  - The timer increments each cycle. Its width is the bits needed to hold TIMEOUT_CYCLES.
  - s_ack_i=1: capture s_dat_i into m_dat_o; drop s_cyc_o/s_stb_o next edge; go to RESP with ack.
  - Timer==TIMEOUT_CYCLES-1 with no ack: load m_dat_o=ERR_DATA (for reads and writes); drop s_cyc_o/s_stb_o; go to RESP with err.
  - Ack and timeout in the same cycle: ack wins, no error is counted.
  - m_cyc_i=0 in BUSY (master abort): drop s_cyc_o/s_stb_o next edge, go to IDLE, issue no response, count no timeout.
- RESP:
  - Exactly one of m_ack_o/m_err_o is high for exactly one cycle, then go to IDLE.
  - m_dat_o holds its value until the next response is loaded.
  - A new m_stb_i during RESP is not accepted. It is sampled again in IDLE; the master keeps stb high until it gets ack/err.
- Latency: slave ack in cycle K gives m_ack_o in cycle K+1. Minimum round trip is 3 cycles (request edge, slave ack, response).
- s_ack_i outside BUSY is ignored. m_ack_o and m_err_o are never asserted together.
- Only one transaction is outstanding at any time. The s_* request fields change only on the IDLE→BUSY edge.
- Synchronous reset during BUSY or RESP: s_cyc_o/s_stb_o and m_ack_o/m_err_o are 0 after that edge; the transaction is dropped silently.

Optional Feature:
- Macro: WB_TIMEOUT_STATUS_EN.
- Defined:
  - Each timeout (not aborts, not ack-wins cases) increments to_count_o, saturating at 16'hFFFF.
  - Each timeout loads to_last_adr_o with the timed-out address.
  - Both are cleared only by rst.
- Undefined: to_count_o and to_last_adr_o are tied to constant 0, with no registers inferred.

Test Plan:
- Read, slave acks 2 cycles after s_stb_o rises, s_dat_i=32'h12345678 → m_ack_o pulses 1 cycle, m_dat_o=32'h12345678, m_err_o stays 0, s_cyc_o low the cycle after the ack.
- Write adr=32'hF000_0004, sel=4'b0011, dat=32'hA5A5_5A5A → s_* carry the identical values for the whole BUSY period; one m_ack_o pulse.
- TIMEOUT_CYCLES=8, slave never acks → s_stb_o high exactly 8 cycles; then one m_err_o pulse, m_dat_o=32'hDEADBEEF. With the macro defined: to_count_o=1, to_last_adr_o=request address.
- s_ack_i asserted in the same cycle the timer reaches its limit → m_ack_o (not m_err_o); to_count_o unchanged.
- m_cyc_i dropped in the 3rd BUSY cycle → s_cyc_o=0 next cycle, no ack/err; a new request 2 cycles later completes normally.
- rst pulsed during BUSY, then a late s_ack_i → all outputs 0 after the reset edge, the late ack is ignored, no m_ack_o.

Source files
------------

// File: rtl/wb_timeout_bridge.sv
// Registered Wishbone bridge that ends any access the slave never acks with an error.
// Optional status counters are enabled with `define WB_TIMEOUT_STATUS_EN.
module wb_timeout_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] m_adr_i,
  input  logic [31:0] m_dat_i,
  output logic [31:0] m_dat_o,
  input  logic        m_we_i,
  input  logic [3:0]  m_sel_i,
  input  logic        m_stb_i,
  input  logic        m_cyc_i,
  output logic        m_ack_o,
  output logic        m_err_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  input  logic [31:0] s_dat_i,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic        s_stb_o,
  output logic        s_cyc_o,
  input  logic        s_ack_i,
  output logic [15:0] to_count_o,
  output logic [31:0] to_last_adr_o
);

  localparam int unsigned   TW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  state_e          state_q, state_d;
  logic [31:0]     adr_q, adr_d, dat_q, dat_d, rdat_q, rdat_d;
  logic            we_q, we_d, err_q, err_d;
  logic [3:0]      sel_q, sel_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            timer_last;
  logic            to_hit;

  assign timer_last = (timer_q == TLAST);
  // A real timeout only: master still present and the slave did not ack this cycle.
  assign to_hit     = (state_q == BUSY) && m_cyc_i && !s_ack_i && timer_last;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (m_cyc_i && m_stb_i) state_d = BUSY;
      BUSY: begin
        if (!m_cyc_i)                   state_d = IDLE;
        else if (s_ack_i || timer_last) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_cyc_o = (state_q == BUSY);
    s_stb_o = (state_q == BUSY);
    m_ack_o = (state_q == RESP) && !err_q;
    m_err_o = (state_q == RESP) && err_q;
  end

  always_comb begin
    adr_d   = adr_q;
    dat_d   = dat_q;
    we_d    = we_q;
    sel_d   = sel_q;
    rdat_d  = rdat_q;
    err_d   = err_q;
    timer_d = timer_q;
    case (state_q)
      IDLE: begin
        if (m_cyc_i && m_stb_i) begin
          adr_d   = m_adr_i;
          dat_d   = m_dat_i;
          we_d    = m_we_i;
          sel_d   = m_sel_i;
          timer_d = '0;
        end
      end
      BUSY: begin
        timer_d = timer_q + TW'(1);
        if (m_cyc_i && s_ack_i) begin
          rdat_d = s_dat_i;
          err_d  = 1'b0;
        end else if (to_hit) begin
          rdat_d = ERR_DATA;
          err_d  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      adr_q   <= '0;
      dat_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      rdat_q  <= '0;
      err_q   <= 1'b0;
      timer_q <= '0;
    end else begin
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      rdat_q  <= rdat_d;
      err_q   <= err_d;
      timer_q <= timer_d;
    end
  end

  assign s_adr_o = adr_q;
  assign s_dat_o = dat_q;
  assign s_we_o  = we_q;
  assign s_sel_o = sel_q;
  assign m_dat_o = rdat_q;

`ifdef WB_TIMEOUT_STATUS_EN
  logic [15:0] to_count_q, to_count_d;
  logic [31:0] to_last_q, to_last_d;

  always_comb begin
    to_count_d = to_count_q;
    to_last_d  = to_last_q;
    if (to_hit) begin
      to_last_d = adr_q;
      if (to_count_q != 16'hFFFF) to_count_d = to_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      to_count_q <= '0;
      to_last_q  <= '0;
    end else begin
      to_count_q <= to_count_d;
      to_last_q  <= to_last_d;
    end
  end

  assign to_count_o    = to_count_q;
  assign to_last_adr_o = to_last_q;
`else
  assign to_count_o    = 16'h0000;
  assign to_last_adr_o = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_wb_timeout_bridge.sv
// Directed, table-driven bench for wb_timeout_bridge with TIMEOUT_CYCLES=8.
module tb_wb_timeout_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] m_adr_i, m_dat_i, m_dat_o;
  logic        m_we_i, m_stb_i, m_cyc_i, m_ack_o, m_err_o;
  logic [3:0]  m_sel_i;
  logic [31:0] s_adr_o, s_dat_o, s_dat_i;
  logic        s_we_o, s_stb_o, s_cyc_o, s_ack_i;
  logic [3:0]  s_sel_o;
  logic [15:0] to_count_o;
  logic [31:0] to_last_adr_o;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  wb_timeout_bridge #(.TIMEOUT_CYCLES(8), .ERR_DATA(32'hDEADBEEF)) dut (
    .clk(clk), .rst(rst),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_dat_o(m_dat_o),
    .m_we_i(m_we_i), .m_sel_i(m_sel_i), .m_stb_i(m_stb_i), .m_cyc_i(m_cyc_i),
    .m_ack_o(m_ack_o), .m_err_o(m_err_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i),
    .s_we_o(s_we_o), .s_sel_o(s_sel_o), .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o),
    .s_ack_i(s_ack_i),
    .to_count_o(to_count_o), .to_last_adr_o(to_last_adr_o)
  );

  // ackDelay is the BUSY cycle index (0 = first) in which the slave acks; -1 = never.
  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    int          ackDelay;
    logic [31:0] slvDat;
    logic        expErr;
    logic [31:0] expDat;
    int          expBusy;
    logic [15:0] expCount;
    logic [31:0] expLast;
  } vec_t;

  vec_t vecs[6];
  vec_t afterAbort;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic checkStatus(input logic [15:0] expCount, input logic [31:0] expLast);
`ifdef WB_TIMEOUT_STATUS_EN
    checkOutput("toCount", 32'(to_count_o), 32'(expCount));
    checkOutput("toLastAdr", to_last_adr_o, expLast);
`else
    checkOutput("toCountTied", 32'(to_count_o), 32'(expCount & 16'h0));
    checkOutput("toLastAdrTied", to_last_adr_o, expLast & 32'h0);
`endif
  endtask

  // Drives one complete transaction from the IDLE state and checks the response.
  task automatic applyStimulus(input vec_t v);
    int   busy = 0;
    logic stableBad = 1'b0;
    m_adr_i = v.adr; m_dat_i = v.dat; m_we_i = v.we; m_sel_i = v.sel;
    m_cyc_i = 1'b1;  m_stb_i = 1'b1;
    @(posedge clk); #1;
    while (s_stb_o === 1'b1 && busy < 40) begin
      if (s_adr_o !== v.adr || s_dat_o !== v.dat || s_we_o !== v.we ||
          s_sel_o !== v.sel || s_cyc_o !== 1'b1 || m_ack_o || m_err_o)
        stableBad = 1'b1;
      s_ack_i = (busy == v.ackDelay);
      s_dat_i = (busy == v.ackDelay) ? v.slvDat : 32'h0BAD_0BAD;
      busy++;
      @(posedge clk); #1;
      s_ack_i = 1'b0;
    end
    checkOutput("reqStable", 32'(stableBad), 32'd0);
    checkOutput("busyCycles", 32'(busy), 32'(v.expBusy));
    checkOutput("respAck", 32'(m_ack_o), 32'(!v.expErr));
    checkOutput("respErr", 32'(m_err_o), 32'(v.expErr));
    checkOutput("respDat", m_dat_o, v.expDat);
    checkOutput("cycDropped", 32'(s_cyc_o), 32'd0);
    checkStatus(v.expCount, v.expLast);
    m_cyc_i = 1'b0; m_stb_i = 1'b0;
    @(posedge clk); #1;
    checkOutput("pulseEnd", 32'({m_ack_o, m_err_o}), 32'd0);
    checkOutput("datHold", m_dat_o, v.expDat);
  endtask

  initial begin
    vecs[0] = '{1'b0, 32'h0000_1000, 32'h0, 4'hF, 2, 32'h1234_5678, 1'b0, 32'h1234_5678, 3, 16'd0, 32'h0};
    vecs[1] = '{1'b1, 32'hF000_0004, 32'hA5A5_5A5A, 4'b0011, 0, 32'h0, 1'b0, 32'h0, 1, 16'd0, 32'h0};
    vecs[2] = '{1'b0, 32'h2000_0010, 32'h0, 4'hF, -1, 32'h0, 1'b1, 32'hDEAD_BEEF, 8, 16'd1, 32'h2000_0010};
    vecs[3] = '{1'b0, 32'h3000_0000, 32'h0, 4'hF, 7, 32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D, 8, 16'd1, 32'h2000_0010};
    vecs[4] = '{1'b1, 32'h4000_0000, 32'h1111_2222, 4'b1000, -1, 32'h0, 1'b1, 32'hDEAD_BEEF, 8, 16'd2, 32'h4000_0000};
    vecs[5] = '{1'b0, 32'h5000_0008, 32'h0, 4'hF, 1, 32'h0000_1111, 1'b0, 32'h0000_1111, 2, 16'd2, 32'h4000_0000};
    afterAbort = '{1'b0, 32'h6000_0000, 32'h0, 4'hF, 1, 32'h0F0F_0F0F, 1'b0, 32'h0F0F_0F0F, 2, 16'd2, 32'h4000_0000};

    rst = 1'b1; m_adr_i = '0; m_dat_i = '0; m_we_i = 1'b0; m_sel_i = '0;
    m_stb_i = 1'b0; m_cyc_i = 1'b0; s_dat_i = '0; s_ack_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("rstCyc", 32'({s_cyc_o, s_stb_o, m_ack_o, m_err_o, s_we_o}), 32'd0);
    checkOutput("rstAdr", s_adr_o, 32'h0);
    checkOutput("rstDat", m_dat_o, 32'h0);
    checkStatus(16'd0, 32'h0);

    for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);

    // Master abort in the third BUSY cycle.
    m_adr_i = 32'h7000_0000; m_we_i = 1'b0; m_cyc_i = 1'b1; m_stb_i = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    checkOutput("abortBusy", 32'(s_stb_o), 32'd1);
    m_cyc_i = 1'b0; m_stb_i = 1'b0;
    @(posedge clk); #1;
    checkOutput("abortCyc", 32'({s_cyc_o, s_stb_o}), 32'd0);
    checkOutput("abortNoResp", 32'({m_ack_o, m_err_o}), 32'd0);
    @(posedge clk); #1;
    checkOutput("abortNoResp2", 32'({m_ack_o, m_err_o}), 32'd0);
    checkOutput("abortDatHold", m_dat_o, 32'h0000_1111);
    checkStatus(16'd2, 32'h4000_0000);
    applyStimulus(afterAbort);

    // Reset in the middle of BUSY, then a late slave ack.
    m_adr_i = 32'h8000_0000; m_cyc_i = 1'b1; m_stb_i = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    checkOutput("preRstBusy", 32'(s_cyc_o), 32'd1);
    rst = 1'b1; m_cyc_i = 1'b0; m_stb_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("midRstCtl", 32'({s_cyc_o, s_stb_o, m_ack_o, m_err_o, s_we_o}), 32'd0);
    checkOutput("midRstAdr", s_adr_o, 32'h0);
    checkOutput("midRstDat", m_dat_o, 32'h0);
    checkStatus(16'd0, 32'h0);
    s_ack_i = 1'b1; s_dat_i = 32'h7777_7777;
    @(posedge clk); #1;
    s_ack_i = 1'b0;
    checkOutput("lateAckIgnored", 32'({m_ack_o, m_err_o, s_cyc_o}), 32'd0);
    checkOutput("lateAckDat", m_dat_o, 32'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
